// File: rtl/mac_result_collector.sv
// mac_result_collector: counts operand pairs issued into the fp16 MAC, waits
// out the MAC pipeline latency after each burst, captures and classifies the
// final accumulator value, and hands it downstream through a small FIFO.
module mac_result_collector #(
  parameter int BURST_LEN   = 8,
  parameter int MAC_LATENCY = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [15:0] acc_in,
  output logic        acc_clear,
  output logic [15:0] res_data,
  output logic [2:0]  res_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        overflow,
  output logic        proto_err
);

  localparam int DATA_W = 16;
  localparam int ENT_W  = DATA_W + 3;
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int DRN_W  = $clog2(MAC_LATENCY + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN);
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(MAC_LATENCY - 1);
  localparam logic [OCC_W-1:0] OCC_ONE    = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN} state_e;

  // fp16 classification as {nan, inf, zero}; the three cases are disjoint.
  function automatic logic [2:0] classify(input logic [DATA_W-1:0] v);
    logic exp_max;
    logic mant_nz;
    exp_max = &v[14:10];
    mant_nz = |v[9:0];
    return {exp_max & mant_nz, exp_max & ~mant_nz, ~|v[14:0]};
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [DRN_W-1:0] drn_cnt_q, drn_cnt_d;
  logic             capture;
  logic             proto_err_q, proto_err_d;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic             overflow_q, overflow_d;
  logic [ENT_W-1:0] entry;
  logic             pop, push_ok, drop;

  // Burst sequencing: count ops, then wait out the MAC latency and capture.
  always_comb begin
    state_d   = state_q;
    op_cnt_d  = op_cnt_q;
    drn_cnt_d = drn_cnt_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_cnt_d  = CNT_ONE;
          drn_cnt_d = DRAIN_LOAD;
          state_d   = (BURST_LEN == 1) ? DRAIN : COUNT;
        end
      end
      COUNT: begin
        if (op_valid) begin
          op_cnt_d = op_cnt_q + 1'b1;
          if ((op_cnt_q + 1'b1) == BURST_LAST) begin
            drn_cnt_d = DRAIN_LOAD;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drn_cnt_q == '0) begin
          capture  = 1'b1;
          op_cnt_d = '0;
          state_d  = IDLE;
        end else begin
          drn_cnt_d = drn_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any op arriving while draining (capture cycle included) is a protocol error.
  always_comb begin
    proto_err_d = proto_err_q | ((state_q == DRAIN) & op_valid);
  end

  // FIFO bookkeeping; a pop frees a slot before the same-cycle push is judged.
  always_comb begin
    entry      = {acc_in, classify(acc_in)};
    pop        = res_valid & res_ready;
    push_ok    = capture & ((occ_q != OCC_FULL) | pop);
    drop       = capture & (occ_q == OCC_FULL) & ~pop;
    overflow_d = overflow_q | drop;
    rd_next    = rd_ptr_q + 1'b1;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_next : rd_ptr_q;
    unique case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    head_d = head_q;
    if (pop && (occ_q > OCC_ONE)) begin
      head_d = mem[rd_next];
    end else if (push_ok && ((occ_q == '0) || (pop && (occ_q == OCC_ONE)))) begin
      head_d = entry;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_cnt_q    <= '0;
      drn_cnt_q   <= '0;
      proto_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      head_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_cnt_q    <= op_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      proto_err_q <= proto_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= entry;
    end
  end

  assign acc_clear = capture;
  assign busy      = (state_q != IDLE);
  assign res_valid = (occ_q != '0);
  assign res_data  = head_q[ENT_W-1:3];
  assign res_flags = head_q[2:0];
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector: directed and randomized bursts
// against a queue-based behavioural model of bursts, latency and the FIFO.
module tb_mac_result_collector;

  localparam int BURST_LEN   = 8;
  localparam int MAC_LATENCY = 2;
  localparam int FIFO_DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [15:0] acc_in = '0;
  logic        res_ready = 1'b0;
  logic        acc_clear;
  logic [15:0] res_data;
  logic [2:0]  res_flags;
  logic        res_valid;
  logic        busy;
  logic        overflow;
  logic        proto_err;

  mac_result_collector #(
    .BURST_LEN  (BURST_LEN),
    .MAC_LATENCY(MAC_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .acc_in   (acc_in),
    .acc_clear(acc_clear),
    .res_data (res_data),
    .res_flags(res_flags),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .overflow (overflow),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int          cyc = 0;
  int          ops_seen = 0;
  int          cap_at = -1;
  logic [15:0] q[$];
  logic [15:0] last_head = '0;
  logic [2:0]  last_flags = '0;
  bit          m_ovf = 0;
  bit          m_perr = 0;

  function automatic logic [2:0] ref_flags(input logic [15:0] v);
    int e;
    int m;
    e = int'(v[14:10]);
    m = int'(v[9:0]);
    if (e == 31 && m != 0) return 3'b100;
    if (e == 31) return 3'b010;
    if (v[14:0] == 15'd0) return 3'b001;
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ops_seen   = 0;
    cap_at     = -1;
    q.delete();
    last_head  = '0;
    last_flags = '0;
    m_ovf      = 0;
    m_perr     = 0;
  endtask

  task automatic model_step(input bit op, input logic [15:0] acc, input bit rdy);
    bit cap_now;
    cap_now = (cap_at == cyc);
    if (op) begin
      if (cap_at >= 0) m_perr = 1;
      else begin
        ops_seen++;
        if (ops_seen == BURST_LEN) begin
          cap_at   = cyc + MAC_LATENCY;
          ops_seen = 0;
        end
      end
    end
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (cap_now) begin
      if (q.size() < FIFO_DEPTH) q.push_back(acc);
      else m_ovf = 1;
      cap_at = -1;
    end
    if (q.size() > 0) begin
      last_head  = q[0];
      last_flags = ref_flags(q[0]);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance, check registers.
  task automatic cycle(input bit op, input logic [15:0] acc, input bit rdy);
    op_valid  = op;
    acc_in    = acc;
    res_ready = rdy;
    #1;
    chk("acc_clear", 32'(acc_clear), 32'(cap_at == cyc));
    chk("busy", 32'(busy), 32'((ops_seen != 0) || (cap_at >= 0)));
    model_step(op, acc, rdy);
    @(posedge clk);
    #1;
    chk("res_valid", 32'(res_valid), 32'(q.size() > 0));
    chk("res_data", 32'(res_data), 32'(last_head));
    chk("res_flags", 32'(res_flags), 32'(last_flags));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    op_valid  = 1'b0;
    res_ready = 1'b0;
    reset     = 1'b0;
    #1;
    model_reset();
    chk("rst_acc_clear", 32'(acc_clear), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_flags", 32'(res_flags), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic bit pick(input int mode);
    if (mode == 2) return bit'($urandom_range(1, 0));
    return (mode != 0);
  endfunction

  // BURST_LEN ops with random gaps, then the drain; rdy_cap applies to the capture cycle.
  task automatic burst(input logic [15:0] val, input int maxgap, input int rdy_run,
                       input bit rdy_cap, input int drain_op_at);
    int g;
    for (int i = 0; i < BURST_LEN; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int j = 0; j < g; j++) cycle(1'b0, val, pick(rdy_run));
      cycle(1'b1, val, pick(rdy_run));
    end
    for (int k = 1; k <= MAC_LATENCY; k++)
      cycle(k == drain_op_at, val, (k == MAC_LATENCY) ? rdy_cap : pick(rdy_run));
  endtask

  task automatic idle(input int n, input int rdy_mode);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), pick(rdy_mode));
  endtask

  initial begin
    logic [15:0] specials [6];
    logic [15:0] v;
    specials[0] = 16'h7C00; specials[1] = 16'hFC00; specials[2] = 16'h7E01;
    specials[3] = 16'h0000; specials[4] = 16'h8000; specials[5] = 16'h3C00;

    // Reset state
    apply_reset();

    // Basic burst
    burst(16'h4800, 0, 1, 1'b1, 0);
    chk("basic_valid", 32'(res_valid), 32'd1);
    chk("basic_data", 32'(res_data), 32'h4800);
    chk("basic_flags", 32'(res_flags), 32'd0);
    chk("basic_busy", 32'(busy), 32'd0);
    idle(2, 1);

    // Gapped burst
    burst(16'h3C00, 3, 1, 1'b1, 0);
    chk("gap_data", 32'(res_data), 32'h3C00);
    idle(2, 1);

    // Classification
    burst(16'h7E00, 0, 1, 1'b1, 0);
    chk("cls_nan", 32'(res_flags), 32'b100);
    burst(16'hFC00, 1, 1, 1'b1, 0);
    chk("cls_inf", 32'(res_flags), 32'b010);
    burst(16'h8000, 2, 1, 1'b1, 0);
    chk("cls_zero", 32'(res_flags), 32'b001);
    idle(2, 1);

    // FIFO full and overflow
    apply_reset();
    burst(16'd1, 0, 0, 1'b0, 0);
    burst(16'd2, 0, 0, 1'b0, 0);
    burst(16'd3, 0, 0, 1'b0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    burst(16'd4, 0, 0, 1'b0, 0);
    chk("ovf_head", 32'(res_data), 32'd1);
    cycle(1'b0, 16'd0, 1'b1);
    chk("ovf_pop1", 32'(res_data), 32'd2);
    cycle(1'b0, 16'd0, 1'b1);
    chk("ovf_empty", 32'(res_valid), 32'd0);
    chk("ovf_hold", 32'(res_data), 32'd2);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and pop at full
    apply_reset();
    burst(16'd1, 0, 0, 1'b0, 0);
    burst(16'd2, 0, 0, 1'b0, 0);
    burst(16'd3, 0, 0, 1'b1, 0);
    chk("pp_head", 32'(res_data), 32'd2);
    chk("pp_ovf", 32'(overflow), 32'd0);
    cycle(1'b0, 16'd0, 1'b1);
    chk("pp_next", 32'(res_data), 32'd3);
    idle(2, 1);

    // Protocol error: op during drain, then op in the capture cycle
    burst(16'h1234, 0, 1, 1'b1, 1);
    chk("perr_drain", 32'(proto_err), 32'd1);
    idle(2, 1);
    apply_reset();
    burst(16'h5678, 0, 1, 1'b1, MAC_LATENCY);
    chk("perr_capture", 32'(proto_err), 32'd1);
    idle(2, 1);

    // Reset one cycle after the last op of a burst
    apply_reset();
    for (int i = 0; i < BURST_LEN; i++) cycle(1'b1, 16'h4400, 1'b0);
    apply_reset();
    idle(4, 0);
    chk("rst_mid_none", 32'(res_valid), 32'd0);
    burst(16'h4600, 0, 1, 1'b1, 0);
    chk("rst_mid_after", 32'(res_data), 32'h4600);
    idle(2, 1);

    // Randomized bursts with random sink back-pressure
    for (int n = 0; n < 30; n++) begin
      v = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : 16'($urandom);
      burst(v, int'($urandom_range(3, 0)), 2, bit'($urandom_range(1, 0)), 0);
      idle(int'($urandom_range(3, 0)), 2);
    end
    idle(6, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
- Consumer end of the fp16 MAC datapath: counts operand pairs issued into the MAC and waits out the MAC pipeline latency after each burst.
- Captures the final 16-bit accumulator value, classifies it, and presents it downstream on a valid/ready interface through a small FIFO.
- Pulses acc_clear so the MAC starts each burst from zero.
- Sits between the operand-feeding wrapper/MAC pair and any result sink (register file, host readback).

Parameters:
- BURST_LEN, 8, operand pairs per accumulation burst (>=1).
- MAC_LATENCY, 2, cycles from the last operand accepted to the valid final acc_in (>=1).
- FIFO_DEPTH, 2, result buffer entries (power of two, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  one operand pair entered the MAC this cycle.
- acc_in  input  16  MAC accumulator output (fp16: sign[15], exp[14:10], mant[9:0]).
- acc_clear  output  1  one-cycle pulse; clears the MAC accumulator.
- res_data  output  16  captured fp16 result at FIFO head.
- res_flags  output  3  {nan, inf, zero} classification of res_data.
- res_valid  output  1  FIFO non-empty.
- res_ready  input  1  sink accepts the head when res_valid is also high.
- busy  output  1  state != IDLE.
- overflow  output  1  sticky: a result was dropped because the FIFO was full.
- proto_err  output  1  sticky: op_valid was seen during DRAIN.

Behaviour:
Reset (reset==0, asynchronous):
- State IDLE; op count and drain count 0; FIFO empty.
- All outputs 0: acc_clear, res_data, res_flags, res_valid, busy, overflow, proto_err.
- Reset mid-burst or mid-drain discards the partial burst; no result is pushed.

State machine:
- IDLE: op_valid -> count=1 -> COUNT. If BURST_LEN==1, go directly to DRAIN instead.
- COUNT: each op_valid increments count. The cycle count reaches BURST_LEN -> DRAIN, drain counter loaded with MAC_LATENCY-1. Cycles without op_valid hold state (gaps allowed).
- DRAIN: drain counter decrements each cycle. When it is 0 in a cycle, that cycle:
  - samples acc_in;
  - pushes {acc_in, flags} into the FIFO;
  - asserts acc_clear for exactly that cycle;
  - next state IDLE.
- An op_valid in DRAIN is ignored (not counted) and sets proto_err.
- An op_valid in the capture cycle itself is also a proto_err.
- Latency: push occurs MAC_LATENCY cycles after the cycle of the last op_valid. res_valid rises the cycle after the push.

Flags, computed on the captured value:
- nan = exp==5'h1F && mant!=0.
- inf = exp==5'h1F && mant==0.
- zero = acc_in[14:0]==0 (both signs).
- At most one flag is set.

FIFO:
- Registered outputs; res_data and res_flags show the head entry.
- res_valid = not empty.
- Pop on res_valid && res_ready.
- Pop and push in the same cycle: both succeed, even when full (pop frees the slot first).
- Push while full with no pop: the new result is dropped, the FIFO is unchanged, and overflow is set until reset.
- res_ready while empty: no effect.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- When empty, res_data and res_flags hold their last value (0 after reset).

Test Plan:
- Basic burst: 8 back-to-back op_valid with acc_in=16'h4800 from cycle after last op, res_ready=1 -> acc_clear pulses 2 cycles after last op; res_valid=1 next cycle with res_data=16'h4800, res_flags=3'b000; busy low after capture.
- Gapped burst: 8 op_valid spread over 20 cycles with random idle gaps -> exactly one push, timed 2 cycles after the 8th op_valid; no early acc_clear.
- Classification: three bursts capturing 16'h7E00, 16'hFC00 and 16'h8000 -> res_flags 3'b100, 3'b010 and 3'b001 respectively.
- FIFO full/overflow: res_ready=0, four bursts with values 1, 2, 3, 4 -> FIFO holds 1, 2; overflow=1 after the third capture; then res_ready=1 -> pops 1 then 2, res_valid drops, overflow stays 1.
- Simultaneous push/pop at full: FIFO holds 1, 2; capture of 3 in the same cycle as a pop -> FIFO holds 2, 3; overflow stays 0.
- Reset mid-drain and protocol error: op_valid in the DRAIN cycle -> proto_err=1. Separate run: reset asserted 1 cycle after the 8th op -> all outputs 0, no result after release; next full burst works normally.
